// File: rtl/mod_exp_ctrl_pkg.sv
// Shared encodings for the Montgomery modular-exponentiation sequencer:
// outer sequencer states, product-call handshake phases and the constant one.
package mod_exp_ctrl_pkg;

  // Widest operand the constant below covers; narrower users truncate it.
  localparam int unsigned ONE_W = 64;
  localparam logic [ONE_W-1:0] ONE = ONE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TO_X,
    ST_TO_ONE,
    ST_SQ,
    ST_MUL,
    ST_FROM,
    ST_FIX
  } state_t;

  // PH_IDLE parks the caller between products; the other three are the call itself.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ISSUE,
    PH_GUARD,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Operand/result bus between the exponentiation sequencer and mon_prod.
interface mod_exp_ctrl_if #(
  parameter int bitLen = 64
);
  logic              mp_start;
  logic [bitLen-1:0] mp_A;
  logic [bitLen-1:0] mp_B;
  logic [bitLen-1:0] mp_M;
  logic              mp_stop;
  logic [bitLen-1:0] mp_P;

  modport master (
    output mp_start,
    output mp_A,
    output mp_B,
    output mp_M,
    input  mp_stop,
    input  mp_P
  );

  modport slave (
    input  mp_start,
    input  mp_A,
    input  mp_B,
    input  mp_M,
    output mp_stop,
    output mp_P
  );
endinterface

// File: rtl/mod_exp_ctrl_mp_call.sv
// One Montgomery product call: latch operands and pulse start, skip one cycle
// in which mon_prod's stop still shows the previous call, then capture P on
// the first stop and hand it back with a one-cycle ack.
module mod_exp_ctrl_mp_call
  import mod_exp_ctrl_pkg::*;
#(
  parameter int bitLen = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [bitLen-1:0] a_i,
  input  logic [bitLen-1:0] b_i,
  input  logic [bitLen-1:0] m_i,
  output logic              ack,
  output logic [bitLen-1:0] prod,
  mod_exp_ctrl_if.master    mp
);

  phase_t            phase_q, phase_d;
  logic              start_q, start_d;
  logic              ack_q, ack_d;
  logic [bitLen-1:0] a_q, a_d;
  logic [bitLen-1:0] b_q, b_d;
  logic [bitLen-1:0] prod_q, prod_d;

  // Handshake phase sequencing; operands are frozen in a_q/b_q until the next request.
  always_comb begin
    phase_d = phase_q;
    start_d = 1'b0;
    ack_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    case (phase_q)
      PH_IDLE: begin
        if (req) begin
          a_d     = a_i;
          b_d     = b_i;
          start_d = 1'b1;
          phase_d = PH_ISSUE;
        end
      end
      PH_ISSUE: phase_d = PH_GUARD;
      // stop may still be high from the previous product here, so it is not looked at.
      PH_GUARD: phase_d = PH_WAIT;
      PH_WAIT: begin
        if (mp.mp_stop) begin
          prod_d  = mp.mp_P;
          ack_d   = 1'b1;
          phase_d = PH_IDLE;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // Handshake state and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      phase_q <= phase_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  assign mp.mp_start = start_q;
  assign mp.mp_A     = a_q;
  assign mp.mp_B     = b_q;
  assign mp.mp_M     = m_i;
  assign ack         = ack_q;
  assign prod        = prod_q;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Y = X^E mod M via Montgomery products: enter the Montgomery domain, run a
// fixed left-to-right square-and-multiply over every exponent bit (a multiply
// only on set bits, no leading-zero skip), leave the domain and reduce once.
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int bitLen   = 64,
  parameter int expLen   = 64,
  parameter int idxWidth = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [bitLen-1:0] X,
  input  logic [expLen-1:0] E,
  input  logic [bitLen-1:0] M,
  input  logic [bitLen-1:0] R2,
  output logic              busy,
  output logic              done,
  output logic [bitLen-1:0] Y,
  mod_exp_ctrl_if.master    mp
);

  localparam logic [bitLen-1:0] ONE_B = bitLen'(ONE);

  state_t              state_q, state_d;
  logic [bitLen-1:0]   x_q, x_d;
  logic [expLen-1:0]   e_q, e_d;
  logic [bitLen-1:0]   m_q, m_d;
  logic [bitLen-1:0]   r2_q, r2_d;
  logic [bitLen-1:0]   xbar_q, xbar_d;
  logic [bitLen-1:0]   acc_q, acc_d;
  logic [idxWidth-1:0] idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [bitLen-1:0]   y_q, y_d;
  logic                pend_q, pend_d;

  logic                ebit;
  logic                call_req;
  logic [bitLen-1:0]   call_a;
  logic [bitLen-1:0]   call_b;
  logic                call_ack;
  logic [bitLen-1:0]   call_prod;

  // Products leave mon_prod in [0, 2M); one conditional subtraction lands in [0, M).
  function automatic logic [bitLen-1:0] cond_sub(input logic [bitLen-1:0] a,
                                                 input logic [bitLen-1:0] m);
    return (a >= m) ? (a - m) : a;
  endfunction

  mod_exp_ctrl_mp_call #(
    .bitLen(bitLen)
  ) u_call (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (call_req),
    .a_i  (call_a),
    .b_i  (call_b),
    .m_i  (m_q),
    .ack  (call_ack),
    .prod (call_prod),
    .mp   (mp)
  );

  // Current exponent bit, operand mux, and one request per product-issuing state visit.
  always_comb begin
    ebit   = |(e_q & (expLen'(1) << idx_q));
    call_a = '0;
    call_b = '0;
    case (state_q)
      ST_TO_X:   begin call_a = x_q;   call_b = r2_q;   end
      ST_TO_ONE: begin call_a = ONE_B; call_b = r2_q;   end
      ST_SQ:     begin call_a = acc_q; call_b = acc_q;  end
      ST_MUL:    begin call_a = acc_q; call_b = xbar_q; end
      ST_FROM:   begin call_a = acc_q; call_b = ONE_B;  end
      default:   begin call_a = '0;    call_b = '0;     end
    endcase
    call_req = !pend_q &&
               ((state_q == ST_TO_X) || (state_q == ST_TO_ONE) || (state_q == ST_SQ) ||
                (state_q == ST_FROM) || ((state_q == ST_MUL) && ebit));
    pend_d   = (pend_q | call_req) & ~call_ack;
  end

  // Outer sequencer: advance on each product ack; clear exponent bits skip the multiply.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    m_d     = m_q;
    r2_d    = r2_q;
    xbar_d  = xbar_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = X;
          e_d     = E;
          m_d     = M;
          r2_d    = R2;
          idx_d   = idxWidth'(expLen - 1);
          busy_d  = 1'b1;
          state_d = ST_TO_X;
        end
      end
      ST_TO_X: begin
        if (call_ack) begin
          xbar_d  = call_prod;
          state_d = ST_TO_ONE;
        end
      end
      ST_TO_ONE: begin
        if (call_ack) begin
          acc_d   = call_prod;
          state_d = ST_SQ;
        end
      end
      ST_SQ: begin
        if (call_ack) begin
          acc_d   = call_prod;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (!ebit || call_ack) begin
          if (ebit) begin
            acc_d = call_prod;
          end
          if (idx_q == '0) begin
            state_d = ST_FROM;
          end else begin
            idx_d   = idx_q - idxWidth'(1);
            state_d = ST_SQ;
          end
        end
      end
      ST_FROM: begin
        if (call_ack) begin
          acc_d   = call_prod;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        y_d     = cond_sub(acc_q, m_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, latched operands, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      r2_q    <= '0;
      xbar_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      e_q     <= e_d;
      m_q     <= m_d;
      r2_q    <= r2_d;
      xbar_q  <= xbar_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural mon_prod (R = 2^10, M = 13).
module tb_mod_exp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x_in;
  logic [7:0]  e_in;
  logic [15:0] m_in;
  logic [15:0] r2_in;
  logic        busy;
  logic        done;
  logic [15:0] y_out;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int stab_checks = 0;
  int stab_err = 0;
  int overlap_err = 0;

  mod_exp_ctrl_if #(.bitLen(16)) mp_bus ();

  mod_exp_ctrl #(
    .bitLen  (16),
    .expLen  (8),
    .idxWidth(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .X    (x_in),
    .E    (e_in),
    .M    (m_in),
    .R2   (r2_in),
    .busy (busy),
    .done (done),
    .Y    (y_out),
    .mp   (mp_bus)
  );

  always #5 clk = ~clk;

  // Montgomery product mod 13 with R = 1024: 1024*4 = 4096 = 315*13 + 1, so R^-1 = 4.
  function automatic logic [15:0] monpro_ref(input logic [15:0] a, input logic [15:0] b,
                                             input bit add_m);
    int unsigned ai;
    int unsigned bi;
    int unsigned r;
    ai = a;
    bi = b;
    r  = ((ai % 13) * (bi % 13) * 4) % 13;
    if (add_m) r += 13;
    return r[15:0];
  endfunction

  logic        stop_m = 1'b0;
  logic [15:0] p_m = '0;
  logic [15:0] pend_m = '0;
  int          cnt_m = 0;
  int          dly_m = 0;
  bit          alt_m = 1'b0;

  assign mp_bus.mp_stop = stop_m;
  assign mp_bus.mp_P    = p_m;

  // mon_prod model: stop stays high (stale) one cycle past start, result 2..20 cycles later.
  always @(posedge clk) begin
    if (mp_bus.mp_start === 1'b1) begin
      cnt_m  = 1;
      dly_m  = $urandom_range(2, 20);
      pend_m = monpro_ref(mp_bus.mp_A, mp_bus.mp_B, alt_m);
      alt_m  = !alt_m;
    end else if (cnt_m != 0) begin
      cnt_m++;
      if (cnt_m >= dly_m) begin
        stop_m <= 1'b1;
        p_m    <= pend_m;
        cnt_m  = 0;
      end else begin
        stop_m <= 1'b0;
      end
    end
  end

  // Pulse counters for mp_start and done.
  always @(posedge clk) begin
    if (mp_bus.mp_start === 1'b1) start_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  logic [15:0] sa, sb, sm;
  bit          win = 1'b0;
  int          wcnt = 0;

  // Operands must hold from mp_start to capture, and no new start may land in that window.
  always @(negedge clk) begin
    if (!rst_n) begin
      win = 1'b0;
    end else if (mp_bus.mp_start === 1'b1) begin
      if (win) overlap_err++;
      win  = 1'b1;
      wcnt = 0;
      sa   = mp_bus.mp_A;
      sb   = mp_bus.mp_B;
      sm   = mp_bus.mp_M;
    end else if (win) begin
      wcnt++;
      stab_checks++;
      if (mp_bus.mp_A !== sa || mp_bus.mp_B !== sb || mp_bus.mp_M !== sm) stab_err++;
      if (wcnt >= 2 && mp_bus.mp_stop === 1'b1) win = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] x, input logic [7:0] e, input logic [15:0] exp_y,
                        input int exp_starts, input bit poke, input string tag);
    int s0;
    int d0;
    bit seen;
    s0    = start_cnt;
    d0    = done_cnt;
    x_in  = x;
    e_in  = e;
    m_in  = 16'd13;
    r2_in = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_on"}, busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (poke && i == 20) begin
        start = 1'b1;
        x_in  = 16'd2;
        e_in  = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_y"}, y_out, exp_y);
    check({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_after"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_mp_starts"}, start_cnt - s0, exp_starts);
  endtask

  initial begin
    int s0;
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    e_in  = '0;
    m_in  = '0;
    r2_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y", y_out, 0);
    check("rst_mp_start", mp_bus.mp_start, 0);
    check("rst_mp_a", mp_bus.mp_A, 0);
    check("rst_mp_b", mp_bus.mp_B, 0);
    check("rst_mp_m", mp_bus.mp_M, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5^3 = 125 = 9*13 + 8; calls 3 + 8 + popcount(3)
    run_op(16'd5, 8'd3, 16'd8, 13, 1'b0, "x5e3");
    run_op(16'd7, 8'd0, 16'd1, 11, 1'b0, "x7e0");
    run_op(16'd7, 8'd1, 16'd7, 12, 1'b0, "x7e1");
    // 2^12 = 4096 = 315*13 + 1 and 255 = 21*12 + 3, so 2^255 mod 13 = 2^3 = 8
    run_op(16'd2, 8'hFF, 16'd8, 19, 1'b0, "x2eff");
    run_op(16'd0, 8'd5, 16'd0, 13, 1'b0, "x0e5");

    // Asynchronous reset while the first SQ product is in flight (third call of X=5, E=0xFF).
    s0    = start_cnt;
    x_in  = 16'd5;
    e_in  = 8'hFF;
    m_in  = 16'd13;
    r2_in = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && (start_cnt - s0) < 3; i++) @(negedge clk);
    check("midrst_reached_sq", start_cnt - s0, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_y", y_out, 0);
    check("midrst_mp_start", mp_bus.mp_start, 0);
    check("midrst_mp_a", mp_bus.mp_A, 0);
    check("midrst_mp_b", mp_bus.mp_B, 0);
    check("midrst_mp_m", mp_bus.mp_M, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3^4 = 81 = 6*13 + 3
    run_op(16'd3, 8'd4, 16'd3, 12, 1'b0, "x3e4");
    // start pulsed mid-run with other operands must be ignored
    run_op(16'd5, 8'd3, 16'd8, 13, 1'b1, "poke");

    check("stab_window_seen", (stab_checks > 0), 1);
    check("stab_operands", stab_err, 0);
    check("no_start_in_wait", overlap_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
